// File: rtl/gtech_sipo8_if.sv
`default_nettype none
// ============================================================================
// Module   : gtech_sipo8_if
// Brief    : Serial-in / parallel-out handshake bundle for gtech_sipo8.
// Revision : 1.0 - initial release
// ============================================================================
interface gtech_sipo8_if #(
    parameter int WIDTH = 8
);
    logic             SI;
    logic             SI_VALID;
    logic             SI_READY;
    logic             SYNC;
    logic [WIDTH-1:0] PO;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic             OVERRUN;

    // Assembler side: consumes the serial stream, produces the parallel word.
    modport slave (
        input  SI,
        input  SI_VALID,
        input  SYNC,
        input  OUT_READY,
        output SI_READY,
        output PO,
        output OUT_VALID,
        output OVERRUN
    );

    // Environment side: serial source and parallel sink.
    modport master (
        output SI,
        output SI_VALID,
        output SYNC,
        output OUT_READY,
        input  SI_READY,
        input  PO,
        input  OUT_VALID,
        input  OVERRUN
    );
endinterface
`default_nettype wire

// File: rtl/gtech_sipo8.sv
`default_nettype none
// ============================================================================
// Module   : gtech_sipo8
// Brief    : Serial-to-parallel word assembler with valid/ready on both sides.
// Revision : 1.0 - initial release
// ============================================================================
module gtech_sipo8 #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  wire logic      CP,
    input  wire logic      CD,
    gtech_sipo8_if.slave   bus
);
    localparam int            CW     = $clog2(WIDTH);
    localparam logic [CW-1:0] C_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_sr;
    logic [WIDTH-1:0] r_po;
    logic [CW-1:0]    r_cnt;
    logic             r_out_valid;
    logic             r_overrun;

    logic [WIDTH-1:0] w_sr_base;
    logic [WIDTH-1:0] w_sr_next;
    logic [CW-1:0]    w_cnt_eff;
    logic [CW-1:0]    w_cnt_next;
    logic             w_last;
    logic             w_ready;
    logic             w_acc;
    logic             w_done;

    // SYNC restarts framing in the same cycle, so the current bit (if any)
    // is evaluated against an empty shift register and a zero count.
    always_comb begin
        w_cnt_eff  = bus.SYNC ? '0 : r_cnt;
        w_sr_base  = bus.SYNC ? '0 : r_sr;
        w_last     = (w_cnt_eff == C_LAST);
        w_ready    = !(w_last && r_out_valid && !bus.OUT_READY);
        w_acc      = bus.SI_VALID && w_ready;
        w_done     = w_acc && w_last;
        w_cnt_next = w_cnt_eff;
        if (w_acc) begin
            w_cnt_next = w_last ? '0 : (w_cnt_eff + CW'(1));
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_sr_next = {w_sr_base[WIDTH-2:0], bus.SI};
        end else begin : g_lsb_first
            assign w_sr_next = {bus.SI, w_sr_base[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge CP) begin
        if (!CD) begin
            r_sr        <= '0;
            r_cnt       <= '0;
            r_po        <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_sr  <= w_acc ? w_sr_next : w_sr_base;
            r_cnt <= w_cnt_next;
            if (bus.SYNC && (r_cnt != '0)) begin
                r_overrun <= 1'b1;
            end
            // A completion wins over a drain so back-to-back words never bubble.
            if (w_done) begin
                r_po        <= w_sr_next;
                r_out_valid <= 1'b1;
            end else if (bus.OUT_READY) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.SI_READY  = w_ready;
    assign bus.PO        = r_po;
    assign bus.OUT_VALID = r_out_valid;
    assign bus.OVERRUN   = r_overrun;
endmodule
`default_nettype wire

// File: tb/tb_gtech_sipo8.sv
`default_nettype none
// ============================================================================
// Module   : tb_gtech_sipo8
// Brief    : Scoreboard bench for gtech_sipo8, MSB-first and LSB-first builds.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gtech_sipo8;
    localparam int W = 8;

    logic CP = 1'b0;
    logic cd = 1'b0, sync = 1'b0, si_valid = 1'b0, si = 1'b0, out_ready = 1'b0;

    gtech_sipo8_if #(.WIDTH(W)) if_m ();
    gtech_sipo8_if #(.WIDTH(W)) if_l ();

    assign if_m.SI = si;  assign if_m.SI_VALID = si_valid;
    assign if_m.SYNC = sync;  assign if_m.OUT_READY = out_ready;
    assign if_l.SI = si;  assign if_l.SI_VALID = si_valid;
    assign if_l.SYNC = sync;  assign if_l.OUT_READY = out_ready;

    gtech_sipo8 #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (.CP(CP), .CD(cd), .bus(if_m));
    gtech_sipo8 #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (.CP(CP), .CD(cd), .bus(if_l));

    always #5 CP = ~CP;

    int n_cmp = 0;
    int n_bad = 0;
    bit started = 1'b0;

    // Reference model: accepted bits of the current word, then words queued
    // for each output ordering; the queue front is what PO should show.
    bit           bits[$];
    logic [W-1:0] q_m[$];
    logic [W-1:0] q_l[$];
    logic [W-1:0] last_po[2];
    bit           exp_ovr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic mon(input int k, input logic v, input logic [W-1:0] po, input logic ovr);
        logic         ev;
        logic [W-1:0] ep;
        ev = (k == 0) ? (q_m.size() > 0) : (q_l.size() > 0);
        ep = ev ? ((k == 0) ? q_m[0] : q_l[0]) : last_po[k];
        chk(k == 0 ? "out_valid_msb" : "out_valid_lsb", {31'd0, v}, {31'd0, ev});
        chk(k == 0 ? "po_msb" : "po_lsb", {24'd0, po}, {24'd0, ep});
        chk(k == 0 ? "overrun_msb" : "overrun_lsb", {31'd0, ovr}, {31'd0, exp_ovr});
        if (ev && out_ready) begin
            last_po[k] = (k == 0) ? q_m.pop_front() : q_l.pop_front();
        end
    endtask

    // Monitor: samples on the falling edge, mid-cycle of the driven inputs.
    always @(negedge CP) begin
        if (started) begin
            mon(0, if_m.OUT_VALID, if_m.PO, if_m.OVERRUN);
            mon(1, if_l.OUT_VALID, if_l.PO, if_l.OVERRUN);
        end
    end

    // One clock of stimulus; the model advances just before the rising edge.
    task automatic step(input logic c, input logic s, input logic v, input logic b,
                        input logic r, output bit acc);
        int           cnt;
        bit           rdy;
        logic [W-1:0] wm, wl;
        cd = c; sync = s; si_valid = v; si = b; out_ready = r;
        #6;
        cnt = s ? 0 : bits.size();
        rdy = !((cnt == W - 1) && (q_m.size() > 0) && !r);
        if (started) begin
            chk("si_ready_msb", {31'd0, if_m.SI_READY}, {31'd0, rdy});
            chk("si_ready_lsb", {31'd0, if_l.SI_READY}, {31'd0, rdy});
        end
        acc = v && rdy;
        if (!c) begin
            bits.delete(); q_m.delete(); q_l.delete();
            last_po[0] = '0; last_po[1] = '0; exp_ovr = 1'b0;
        end else begin
            if (s) begin
                if (bits.size() != 0) exp_ovr = 1'b1;
                bits.delete();
            end
            if (acc) begin
                bits.push_back(b);
                if (bits.size() == W) begin
                    wm = '0; wl = '0;
                    for (int i = 0; i < W; i++) begin
                        wm = wm + (W'(bits[i]) << (W - 1 - i));
                        wl = wl + (W'(bits[i]) << i);
                    end
                    q_m.push_back(wm);
                    q_l.push_back(wl);
                    bits.delete();
                end
            end
        end
        @(posedge CP);
        #1;
    endtask

    // Sends a word in time order w[7] first, holding each bit until taken.
    task automatic send_word(input logic [7:0] w, input logic r);
        bit acc;
        int tries;
        for (int i = 7; i >= 0; i--) begin
            tries = 0;
            do begin
                step(1'b1, 1'b0, 1'b1, w[i], r, acc);
                tries++;
            end while (!acc && tries < 50);
            if (!acc) chk("send_word_timeout", 32'd0, 32'd1);
        end
    endtask

    task automatic idle(input int n, input logic r);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, r, acc);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        bit hold_v, hold_b, c, s, v, b, r;
        exp_ovr = 1'b0; last_po[0] = '0; last_po[1] = '0;
        @(posedge CP); #1;

        // Reset then idle
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        started = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        idle(20, 1'b1);

        // A5 and C0 in time order: MSB build gives A5/C0, LSB build A5/03
        send_word(8'hA5, 1'b1);
        idle(3, 1'b1);
        send_word(8'hC0, 1'b1);
        idle(3, 1'b1);

        // Backpressure: 3C pending, C3 completing bit stalls, then one-cycle drain
        send_word(8'h3C, 1'b0);
        for (int i = 7; i >= 1; i--) step(1'b1, 1'b0, 1'b1, 1'(8'hC3 >> i), 1'b0, acc);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, acc);
        idle(3, 1'b0);

        // SYNC mid-word while C3 still pending
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, acc);
        step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, acc);
        chk("overrun_after_sync", {31'd0, if_m.OVERRUN}, 32'd1);
        for (int i = 6; i >= 0; i--) step(1'b1, 1'b0, 1'b1, 1'(7'h01 >> i), 1'b0, acc);
        idle(2, 1'b0);
        idle(4, 1'b1);

        // Reset with a pending 5A and four bits of the next word
        send_word(8'h5A, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
        chk("po_after_reset", {24'd0, if_m.PO}, 32'd0);
        chk("overrun_after_reset", {31'd0, if_m.OVERRUN}, 32'd0);
        send_word(8'hFF, 1'b1);
        idle(3, 1'b1);

        // Random traffic; a stalled bit is held until accepted
        hold_v = 1'b0; hold_b = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            c = ($urandom_range(0, 199) != 0);
            s = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 9) < 6);
            if (hold_v) begin
                v = 1'b1; b = hold_b;
            end else begin
                v = ($urandom_range(0, 9) < 7);
                b = 1'($urandom);
            end
            step(c, s, v, b, r, acc);
            hold_v = v && !acc && c;
            hold_b = b;
        end
        idle(20, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
